// File: rtl/vector_sequencer.sv
// Test-vector player: drives stored control words onto the ALU control bus and
// checks the masked observation of each applied vector.
//
// state | meaning
// IDLE  | after reset, no run yet
// RUN   | one vector on Ctrl_Out this cycle, compared at the closing edge
// WAIT  | between vectors; issue_q set means the next vector is being fetched
// DONE  | run finished, results held until next Start
module vector_sequencer #(
  parameter int WORD_W = 40,
  parameter int CHK_W = 8,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Ld_En,
  input  logic [AW-1:0]             Ld_Addr,
  input  logic [WORD_W+2*CHK_W-1:0] Ld_Data,
  input  logic [AW:0]               Len,
  input  logic                      Start,
  input  logic                      Step_Mode,
  input  logic                      Step,
  input  logic                      Stop_On_Err,
  input  logic                      Abort,
  input  logic [CHK_W-1:0]          Obs,
  output logic [WORD_W-1:0]         Ctrl_Out,
  output logic                      Ctrl_Valid,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Err_Flag,
  output logic [15:0]               Err_Count,
  output logic [AW:0]               First_Err_Idx,
  output logic [AW:0]               Vec_Num
);

  localparam int ENT_W = WORD_W + 2 * CHK_W;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic             issue_q, issue_nxt;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW:0]      len_q;
  logic             step_q, soe_q;
  logic [CHK_W-1:0] exp_q, mask_q;
  logic [AW:0]      vec_inc;
  logic [AW-1:0]    rd_addr;
  logic             mismatch, last_vec, start_go;

  assign Ctrl_Valid = (state == ST_RUN);
  assign Busy       = (state == ST_RUN) || (state == ST_WAIT);
  assign Done       = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    issue_nxt = 1'b0;
    start_go  = 1'b0;
    vec_inc   = Vec_Num + (AW+1)'(1);
    rd_addr   = Vec_Num[AW-1:0];
    mismatch  = |((Obs ^ exp_q) & mask_q);
    last_vec  = (vec_inc == len_q);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          start_go = 1'b1;
          if (Len == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_WAIT;
            issue_nxt = !Step_Mode;
          end
        end
      end
      ST_WAIT: begin
        if (Abort)        state_nxt = ST_DONE;
        else if (issue_q) state_nxt = ST_RUN;
        else              issue_nxt = Step;
      end
      ST_RUN: begin
        // prefetch the following entry so free-run has no gaps
        rd_addr = vec_inc[AW-1:0];
        if (Abort)                               state_nxt = ST_DONE;
        else if (last_vec || (mismatch && soe_q)) state_nxt = ST_DONE;
        else if (step_q)                         state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= ST_IDLE;
      issue_q       <= 1'b0;
      len_q         <= '0;
      step_q        <= 1'b0;
      soe_q         <= 1'b0;
      Vec_Num       <= '0;
      Err_Count     <= '0;
      Err_Flag      <= 1'b0;
      First_Err_Idx <= '0;
      Ctrl_Out      <= IDLE_WORD;
      exp_q         <= '0;
      mask_q        <= '0;
    end else begin
      state   <= state_nxt;
      issue_q <= issue_nxt;
      if (state_nxt == ST_RUN) {Ctrl_Out, exp_q, mask_q} <= mem[rd_addr];
      else                     Ctrl_Out <= IDLE_WORD;
      if (start_go) begin
        len_q         <= Len;
        step_q        <= Step_Mode;
        soe_q         <= Stop_On_Err;
        Vec_Num       <= '0;
        Err_Count     <= '0;
        Err_Flag      <= 1'b0;
        First_Err_Idx <= '0;
      end else if (state == ST_RUN && !Abort) begin
        if (mismatch) begin
          if (Err_Count != 16'hFFFF) Err_Count <= Err_Count + 16'd1;
          if (!Err_Flag) begin
            Err_Flag      <= 1'b1;
            First_Err_Idx <= Vec_Num;
          end
        end
        Vec_Num <= vec_inc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Ld_En && !Busy) mem[Ld_Addr] <= Ld_Data;
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: cycle-level reference model compared every cycle,
// plus literal checks of the documented scenarios and a saturation run.
module tb_vector_sequencer;

  localparam int WW = 40;
  localparam int CW = 8;
  localparam int DP = 256;
  localparam int EW = WW + 2 * CW;
  localparam logic [WW-1:0] IDLE = 40'hA5_0000_005A;

  localparam int P_IDLE = 0, P_WAIT = 1, P_APPLY = 2, P_DONE = 3;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 0;

  logic          Clock = 0;
  logic          Reset, Ld_En, Start, Step_Mode, Step, Stop_On_Err, Abort;
  logic [7:0]    Ld_Addr;
  logic [EW-1:0] Ld_Data;
  logic [8:0]    Len;
  logic [CW-1:0] Obs;
  logic [WW-1:0] Ctrl_Out;
  logic          Ctrl_Valid, Busy, Done, Err_Flag;
  logic [15:0]   Err_Count;
  logic [8:0]    First_Err_Idx, Vec_Num;

  // saturation instance: 2^17 entries so a single run can hold 65537 vectors
  logic          s_Start, s_zero1;
  logic [16:0]   s_Ld_Addr;
  logic [5:0]    s_Ld_Data;
  logic [17:0]   s_Len;
  logic [0:0]    s_Obs;
  logic [3:0]    s_Ctrl_Out;
  logic          s_Ctrl_Valid, s_Busy, s_Done, s_Err_Flag;
  logic [15:0]   s_Err_Count;
  logic [17:0]   s_First_Err_Idx, s_Vec_Num;

  always #5 Clock = ~Clock;

  function automatic logic [7:0] fobs(logic [WW-1:0] c);
    return c[7:0] ^ c[39:32];
  endfunction

  assign Obs = fobs(Ctrl_Out);

  vector_sequencer #(.WORD_W(WW), .CHK_W(CW), .DEPTH(DP), .IDLE_WORD(IDLE)) dut (
    .Clock(Clock), .Reset(Reset), .Ld_En(Ld_En), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data),
    .Len(Len), .Start(Start), .Step_Mode(Step_Mode), .Step(Step), .Stop_On_Err(Stop_On_Err),
    .Abort(Abort), .Obs(Obs), .Ctrl_Out(Ctrl_Out), .Ctrl_Valid(Ctrl_Valid), .Busy(Busy),
    .Done(Done), .Err_Flag(Err_Flag), .Err_Count(Err_Count), .First_Err_Idx(First_Err_Idx),
    .Vec_Num(Vec_Num));

  vector_sequencer #(.WORD_W(4), .CHK_W(1), .DEPTH(131072), .IDLE_WORD(4'h0)) u_sat (
    .Clock(Clock), .Reset(Reset), .Ld_En(s_zero1), .Ld_Addr(s_Ld_Addr), .Ld_Data(s_Ld_Data),
    .Len(s_Len), .Start(s_Start), .Step_Mode(s_zero1), .Step(s_zero1), .Stop_On_Err(s_zero1),
    .Abort(s_zero1), .Obs(s_Obs), .Ctrl_Out(s_Ctrl_Out), .Ctrl_Valid(s_Ctrl_Valid),
    .Busy(s_Busy), .Done(s_Done), .Err_Flag(s_Err_Flag), .Err_Count(s_Err_Count),
    .First_Err_Idx(s_First_Err_Idx), .Vec_Num(s_Vec_Num));

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int phase;
    bit fetch;
    int len;
    int vec;
    int cnt;
    int first;
    bit flag;
    bit step;
    bit soe;
  } mstate_t;

  mstate_t       ms = '{default: 0};
  logic [EW-1:0] m_mem [DP];

  function automatic mstate_t m_next(mstate_t s);
    mstate_t n = s;
    logic [EW-1:0] e;
    bit mm;
    n.fetch = 0;
    if (Reset) begin
      n = '{default: 0};
      return n;
    end
    case (s.phase)
      P_IDLE, P_DONE: if (Start) begin
        n.cnt = 0; n.first = 0; n.flag = 0; n.vec = 0;
        n.len = int'(Len); n.step = Step_Mode; n.soe = Stop_On_Err;
        if (Len == 0) n.phase = P_DONE;
        else begin
          n.phase = P_WAIT;
          n.fetch = !Step_Mode;
        end
      end
      P_WAIT: begin
        if (Abort)        n.phase = P_DONE;
        else if (s.fetch) n.phase = P_APPLY;
        else              n.fetch = Step;
      end
      default: begin
        if (Abort) n.phase = P_DONE;
        else begin
          e  = m_mem[s.vec % DP];
          mm = ((fobs(e[EW-1:2*CW]) ^ e[2*CW-1:CW]) & e[CW-1:0]) != 0;
          if (mm) begin
            if (s.cnt < 65535) n.cnt = s.cnt + 1;
            if (!s.flag) begin
              n.flag = 1;
              n.first = s.vec;
            end
          end
          n.vec = s.vec + 1;
          if (n.vec == s.len || (mm && s.soe)) n.phase = P_DONE;
          else if (s.step)                     n.phase = P_WAIT;
          else                                 n.phase = P_APPLY;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge Clock) begin
    if (Ld_En && !(ms.phase == P_WAIT || ms.phase == P_APPLY)) m_mem[Ld_Addr] <= Ld_Data;
    ms <= m_next(ms);
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("cyc_ctrl_valid", Ctrl_Valid, ms.phase == P_APPLY);
      chk("cyc_ctrl_out", Ctrl_Out,
          (ms.phase == P_APPLY) ? m_mem[ms.vec % DP][EW-1:2*CW] : IDLE);
      chk("cyc_busy", Busy, ms.phase == P_WAIT || ms.phase == P_APPLY);
      chk("cyc_done", Done, ms.phase == P_DONE);
      chk("cyc_err_flag", Err_Flag, ms.flag);
      chk("cyc_err_count", Err_Count, ms.cnt);
      chk("cyc_first_err", First_Err_Idx, ms.first);
      chk("cyc_vec_num", Vec_Num, ms.vec);
    end
  end

  // ---------------- stimulus ----------------
  logic [WW-1:0] saved_ctrl [DP];

  function automatic logic [WW-1:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic load(int a, logic [WW-1:0] c, logic [7:0] diff, logic [7:0] mask);
    Ld_En = 1; Ld_Addr = 8'(a); Ld_Data = {c, fobs(c) ^ diff, mask};
    @(negedge Clock);
    Ld_En = 0;
    saved_ctrl[a] = c;
  endtask

  task automatic start(int len, bit st, bit soe);
    Start = 1; Len = 9'(len); Step_Mode = st; Stop_On_Err = soe;
    @(negedge Clock);
    Start = 0;
  endtask

  task automatic run_wait(int budget, output int done_at, output int vcnt);
    int n = 0;
    vcnt = 0;
    while (!Done && n < budget) begin
      if (Ctrl_Valid) vcnt++;
      @(negedge Clock);
      n++;
    end
    done_at = n;
  endtask

  task automatic pulse_step();
    Step = 1;
    @(negedge Clock);
    Step = 0;
  endtask

  initial begin
    for (int i = 0; i < 65537; i++) u_sat.mem[i] <= 6'b1010_11;
  end

  initial begin
    int d, v, n;
    Reset = 1; Ld_En = 0; Start = 0; Step_Mode = 0; Step = 0; Stop_On_Err = 0; Abort = 0;
    Ld_Addr = 0; Ld_Data = 0; Len = 0;
    s_Start = 0; s_zero1 = 0; s_Ld_Addr = 0; s_Ld_Data = 0; s_Len = 0; s_Obs = 1'b0;
    repeat (3) @(negedge Clock);
    cmp_en = 1;
    chk("rst_ctrl_out", Ctrl_Out, IDLE);
    chk("rst_valid", Ctrl_Valid, 0);
    chk("rst_done", Done, 0);
    chk("rst_vec_num", Vec_Num, 0);
    Reset = 0;
    @(negedge Clock);

    // free run, all matching
    for (int i = 0; i < 4; i++) load(i, rnd40(), 8'h00, 8'hFF);
    start(4, 0, 0);
    run_wait(20, d, v);
    chk("free_done_at", d, 5);
    chk("free_valid_cycles", v, 4);
    chk("free_err_count", Err_Count, 0);
    chk("free_err_flag", Err_Flag, 0);
    chk("free_vec_num", Vec_Num, 4);

    // single mismatch at vector 2, then same difference hidden by mask
    load(2, saved_ctrl[2], 8'h10, 8'hFF);
    start(4, 0, 0);
    run_wait(20, d, v);
    chk("mm2_err_count", Err_Count, 1);
    chk("mm2_first_idx", First_Err_Idx, 2);
    chk("mm2_vec_num", Vec_Num, 4);
    load(2, saved_ctrl[2], 8'h10, 8'hEF);
    start(4, 0, 0);
    run_wait(20, d, v);
    chk("masked_err_count", Err_Count, 0);
    chk("masked_err_flag", Err_Flag, 0);

    // stop on first error
    for (int i = 0; i < 5; i++) load(i, rnd40(), (i == 1 || i == 3) ? 8'h01 : 8'h00, 8'hFF);
    start(5, 0, 1);
    run_wait(20, d, v);
    chk("soe_done_at", d, 3);
    chk("soe_vec_num", Vec_Num, 2);
    chk("soe_first_idx", First_Err_Idx, 1);
    chk("soe_err_count", Err_Count, 1);

    // step mode, with a dropped load while waiting
    for (int i = 0; i < 3; i++) load(i, rnd40(), 8'h00, 8'hFF);
    start(3, 1, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        Ld_En = 1; Ld_Addr = 8'd1; Ld_Data = {rnd40(), 16'h00FF};
        @(negedge Clock);
        Ld_En = 0;
      end
      @(negedge Clock);
      chk("step_gap_valid", Ctrl_Valid, 0);
      chk("step_gap_ctrl", Ctrl_Out, IDLE);
      pulse_step();
      @(negedge Clock);
      chk("step_valid", Ctrl_Valid, 1);
      chk("step_vec_num", Vec_Num, k);
      chk("step_ctrl", Ctrl_Out, saved_ctrl[k]);
      @(negedge Clock);
    end
    chk("step_done", Done, 1);
    pulse_step();
    @(negedge Clock);
    chk("step_extra_done", Done, 1);
    chk("step_extra_vec", Vec_Num, 3);

    // empty run
    start(0, 0, 0);
    run_wait(5, d, v);
    chk("len0_done_at", d, 0);
    chk("len0_valid_cycles", v, 0);

    // full depth with random errors
    for (int i = 0; i < DP; i++)
      load(i, rnd40(), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom));
    start(DP, 0, 0);
    run_wait(400, d, v);
    chk("full_done_at", d, DP + 1);
    chk("full_vec_num", Vec_Num, DP);

    // abort at vector 5
    start(20, 0, 0);
    n = 0;
    while (!(Ctrl_Valid && Vec_Num == 5) && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("abort_reached_v5", n < 40, 1);
    Abort = 1;
    @(negedge Clock);
    Abort = 0;
    chk("abort_done", Done, 1);
    chk("abort_ctrl", Ctrl_Out, IDLE);
    chk("abort_vec_num", Vec_Num, 5);

    // reset mid-run, memory retained afterwards
    start(20, 0, 0);
    repeat (4) @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    Reset = 0;
    chk("rstrun_ctrl", Ctrl_Out, IDLE);
    chk("rstrun_busy", Busy, 0);
    chk("rstrun_vec", Vec_Num, 0);
    chk("rstrun_done", Done, 0);
    start(6, 0, 0);
    run_wait(20, d, v);
    chk("rerun_vec_num", Vec_Num, 6);

    // randomized runs
    for (int it = 0; it < 14; it++) begin
      start($urandom_range(1, 40), 1'($urandom), 1'($urandom));
      n = 0;
      while (!Done && n < 3000) begin
        Step    = ($urandom_range(0, 3) == 0);
        Abort   = ($urandom_range(0, 80) == 0);
        Start   = ($urandom_range(0, 15) == 0);
        Ld_En   = ($urandom_range(0, 7) == 0);
        Ld_Addr = 8'($urandom);
        Ld_Data = {rnd40(), 16'($urandom)};
        @(negedge Clock);
        n++;
      end
      Step = 0; Abort = 0; Start = 0; Ld_En = 0;
      chk("rand_done", Done, 1);
      @(negedge Clock);
    end

    // error counter saturation
    s_Start = 1; s_Len = 18'd65537;
    @(negedge Clock);
    s_Start = 0;
    n = 0;
    while (!s_Done && n < 70000) begin
      @(negedge Clock);
      n++;
    end
    chk("sat_err_count", s_Err_Count, 16'hFFFF);
    chk("sat_vec_num", s_Vec_Num, 65537);
    chk("sat_first_idx", s_First_Err_Idx, 0);
    chk("sat_err_flag", s_Err_Flag, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
